// File: rtl/rx_fifo_bus_if_mc.sv
// Bus-side register interface for NUM_CH USB RX endpoint FIFOs: data pop with ack
// handshake, coherent 16-bit count reads, threshold interrupts, underflow flags and flush pulses.
module rx_fifo_bus_if_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      busClk,
    input  logic                      rstN,
    input  logic [CH_W+2:0]           address,
    input  logic                      writeEn,
    input  logic                      strobe_i,
    input  logic [7:0]                busDataIn,
    output logic [7:0]                busDataOut,
    output logic                      ackOut,
    output logic [NUM_CH-1:0]         fifoREn,
    input  logic [NUM_CH*8-1:0]       fifoDataIn,
    input  logic [NUM_CH*CNT_W-1:0]   numElementsInFifo,
    output logic [NUM_CH-1:0]         forceEmpty,
    output logic [NUM_CH-1:0]         irq
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] REG_DATA     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_COUNT_HI = 3'd2;
    localparam logic [2:0] REG_COUNT_LO = 3'd3;
    localparam logic [2:0] REG_CONTROL  = 3'd4;
    localparam logic [2:0] REG_THR_HI   = 3'd5;
    localparam logic [2:0] REG_THR_LO   = 3'd6;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state;
    logic [1:0]        wait_cnt;
    logic [CH_W-1:0]   ch_q;
    logic [2:0]        reg_q;
    logic              we_q;
    logic              ch_ok_q;
    logic              pop_q;
    logic [7:0]        wdata_q;
    logic [7:0]        pop_data;

    logic [15:0]       thr      [NUM_CH];
    logic [7:0]        shadow   [NUM_CH];
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] underflow;

    logic [15:0]       count     [NUM_CH];
    logic [7:0]        fifo_byte [NUM_CH];
    logic [NUM_CH-1:0] thr_hit;
    logic [NUM_CH-1:0] empty;

    logic [CH_W-1:0]   req_ch;
    logic [2:0]        req_reg;
    logic              req_ch_ok;
    logic              req_pop;
    logic [NUM_CH-1:0] req_onehot;
    logic [7:0]        rd_mux;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign count[g]     = 16'(numElementsInFifo[g*CNT_W +: CNT_W]);
        assign fifo_byte[g] = fifoDataIn[g*8 +: 8];
        assign thr_hit[g]   = (thr[g] != 16'd0) && (count[g] >= thr[g]);
        assign empty[g]     = (count[g] == 16'd0);
    end

    // Channels beyond NUM_CH still get acked but never touch per-channel state.
    assign req_ch     = address[CH_W+2:3];
    assign req_reg    = address[2:0];
    assign req_ch_ok  = ({1'b0, req_ch} < (CH_W+1)'(NUM_CH));
    assign req_pop    = req_ch_ok && !writeEn && (req_reg == REG_DATA) && (count[req_ch] != 16'd0);
    assign req_onehot = NUM_CH'(1) << req_ch;

    always_comb begin
        rd_mux = 8'h00;
        if (ch_ok_q) begin
            case (reg_q)
                REG_DATA:     rd_mux = pop_q ? pop_data : 8'h00;
                REG_STATUS:   rd_mux = {5'b0, underflow[ch_q], thr_hit[ch_q], empty[ch_q]};
                REG_COUNT_HI: rd_mux = count[ch_q][15:8];
                REG_COUNT_LO: rd_mux = shadow[ch_q];
                REG_CONTROL:  rd_mux = {5'b0, irq_en[ch_q], 2'b0};
                REG_THR_HI:   rd_mux = thr[ch_q][15:8];
                REG_THR_LO:   rd_mux = thr[ch_q][7:0];
                default:      rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge busClk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            wait_cnt   <= 2'd0;
            ch_q       <= '0;
            reg_q      <= 3'd0;
            we_q       <= 1'b0;
            ch_ok_q    <= 1'b0;
            pop_q      <= 1'b0;
            wdata_q    <= 8'h00;
            pop_data   <= 8'h00;
            busDataOut <= 8'h00;
            ackOut     <= 1'b0;
            fifoREn    <= '0;
            forceEmpty <= '0;
            irq        <= '0;
            irq_en     <= '0;
            underflow  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                thr[c]    <= 16'd0;
                shadow[c] <= 8'h00;
            end
        end else begin
            ackOut     <= 1'b0;
            fifoREn    <= '0;
            forceEmpty <= '0;
            irq        <= irq_en & thr_hit;

            case (state)
                S_IDLE: begin
                    if (strobe_i) begin
                        ch_q    <= req_ch;
                        reg_q   <= req_reg;
                        we_q    <= writeEn;
                        ch_ok_q <= req_ch_ok;
                        wdata_q <= busDataIn;
                        pop_q   <= req_pop;
                        if (req_pop) begin
                            fifoREn <= req_onehot;
                            state   <= S_POP;
                        end else begin
                            state   <= S_ACK;
                        end
                    end
                end
                S_POP: begin
                    wait_cnt <= 2'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        pop_data <= fifo_byte[ch_q];
                        state    <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_ACK: begin
                    ackOut <= 1'b1;
                    if (we_q) begin
                        if (ch_ok_q) begin
                            case (reg_q)
                                REG_CONTROL: begin
                                    if (wdata_q[0]) begin
                                        forceEmpty[ch_q] <= 1'b1;
                                        shadow[ch_q]     <= 8'h00;
                                    end
                                    if (wdata_q[1]) underflow[ch_q] <= 1'b0;
                                    irq_en[ch_q] <= wdata_q[2];
                                end
                                REG_THR_HI: thr[ch_q][15:8] <= wdata_q;
                                REG_THR_LO: thr[ch_q][7:0]  <= wdata_q;
                                default: ;
                            endcase
                        end
                    end else begin
                        busDataOut <= rd_mux;
                        // The low byte is frozen at the same instant the high byte is returned.
                        if (ch_ok_q && reg_q == REG_COUNT_HI) shadow[ch_q] <= count[ch_q][7:0];
                        if (ch_ok_q && reg_q == REG_DATA && !pop_q) underflow[ch_q] <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!strobe_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
